// File: rtl/tdm_demux4_if.sv
// Link between the serial TDM stream source and the 4-lane demultiplexer.
// The master drives the serial side; the slave returns the assembled lane words.
interface tdm_demux4_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_bit;
    logic             in_sof;
    logic [1:0]       slot;
    logic             locked;
    logic             out_valid;
    logic [WIDTH-1:0] out0;
    logic [WIDTH-1:0] out1;
    logic [WIDTH-1:0] out2;
    logic [WIDTH-1:0] out3;
    logic             sync_err;

    modport master (
        output in_valid, in_bit, in_sof,
        input  slot, locked, out_valid, out0, out1, out2, out3, sync_err
    );

    modport slave (
        input  in_valid, in_bit, in_sof,
        output slot, locked, out_valid, out0, out1, out2, out3, sync_err
    );
endinterface

// File: rtl/tdm_demux4.sv
// Receive side of a 4:1 round-robin bit-interleaved link: routes each serial
// bit to its lane and presents one WIDTH-bit word per lane once a frame completes.
module tdm_demux4 #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    tdm_demux4_if.slave  bus
);
    localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BCW-1:0] LAST = BCW'(WIDTH - 1);

    typedef enum logic {UNLOCK = 1'b0, LOCK = 1'b1} state_t;

    state_t           state_q, state_d;
    logic             locked_q, locked_d;
    logic [1:0]       slot_q, slot_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic             sync_err_q, sync_err_d;
    logic [WIDTH-1:0] lane_q [4];
    logic [WIDTH-1:0] lane_d [4];
    logic [WIDTH-1:0] out_q  [4];
    logic [WIDTH-1:0] out_d  [4];
    logic [WIDTH-1:0] cur_lane;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] sof_word;
    logic             restart;

    always_comb begin
        state_d     = state_q;
        locked_d    = locked_q;
        slot_d      = slot_q;
        bit_cnt_d   = bit_cnt_q;
        out_valid_d = 1'b0;
        sync_err_d  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            lane_d[i] = lane_q[i];
            out_d[i]  = out_q[i];
        end
        cur_lane = lane_q[slot_q];
        shifted  = {bus.in_bit, cur_lane[WIDTH-1:1]};
        sof_word = {bus.in_bit, {(WIDTH-1){1'b0}}};
        // A sof restarts the frame unless it lands exactly on the expected boundary.
        restart  = bus.in_sof &&
                   ((state_q == UNLOCK) || (slot_q != 2'd0) || (bit_cnt_q != '0));

        if (bus.in_valid) begin
            if (restart) begin
                sync_err_d = (state_q == LOCK);
                state_d    = LOCK;
                locked_d   = 1'b1;
                slot_d     = 2'd1;
                bit_cnt_d  = '0;
                for (int i = 0; i < 4; i++) lane_d[i] = '0;
                lane_d[0]  = sof_word;
            end else if (state_q == LOCK) begin
                lane_d[slot_q] = shifted;
                slot_d         = slot_q + 2'd1;
                if (slot_q == 2'd3) begin
                    if (bit_cnt_q == LAST) begin
                        bit_cnt_d   = '0;
                        out_valid_d = 1'b1;
                        out_d[0]    = lane_q[0];
                        out_d[1]    = lane_q[1];
                        out_d[2]    = lane_q[2];
                        out_d[3]    = shifted;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= UNLOCK;
            locked_q    <= 1'b0;
            slot_q      <= 2'd0;
            bit_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                lane_q[i] <= '0;
                out_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            locked_q    <= locked_d;
            slot_q      <= slot_d;
            bit_cnt_q   <= bit_cnt_d;
            out_valid_q <= out_valid_d;
            sync_err_q  <= sync_err_d;
            for (int i = 0; i < 4; i++) begin
                lane_q[i] <= lane_d[i];
                out_q[i]  <= out_d[i];
            end
        end
    end

    assign bus.slot      = slot_q;
    assign bus.locked    = locked_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sync_err  = sync_err_q;
    assign bus.out0      = out_q[0];
    assign bus.out1      = out_q[1];
    assign bus.out2      = out_q[2];
    assign bus.out3      = out_q[3];
endmodule
